// File: rtl/operand_bypass_net.sv
// Operand forwarding network for EXE: resolves sources against prioritised producer stages,
// holds resolved operands in capture registers while the stage stalls, and counts bypass stalls.
module operand_bypass_net #(
   parameter int XLEN     = 64,
   parameter int NUM_SRC  = 3,
   parameter int NUM_PROD = 2,
   parameter int RA_W     = 5,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cons_ready,
   input  logic                     cons_flush,
   input  logic [NUM_SRC-1:0]       src_en,
   input  logic [NUM_SRC*RA_W-1:0]  src_addr,
   input  logic [NUM_SRC*XLEN-1:0]  src_rf,
   input  logic [NUM_PROD-1:0]      prod_en,
   input  logic [NUM_PROD*RA_W-1:0] prod_addr,
   input  logic [NUM_PROD*XLEN-1:0] prod_data,
   input  logic [NUM_PROD-1:0]      prod_pend,
   output logic                     out_valid,
   output logic [NUM_SRC*XLEN-1:0]  out_data,
   output logic [NUM_SRC-1:0]       out_src_ok,
   output logic [CNT_W-1:0]         stall_cnt
);

   logic [XLEN-1:0]    live_val [NUM_SRC];
   logic [NUM_SRC-1:0] live_ok;
   logic [NUM_SRC-1:0] hit_any;
   logic [NUM_SRC-1:0] zero_src;
   logic [NUM_SRC-1:0] cap_flag;
   logic [XLEN-1:0]    cap_data [NUM_SRC];
   logic               stall_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Youngest matching producer wins; a pending youngest hit blocks the source outright.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         zero_src[i] = (ZERO_REG != 0) && (src_addr[i*RA_W +: RA_W] == '0);
         hit_any[i]  = 1'b0;
         live_ok[i]  = 1'b1;
         live_val[i] = src_rf[i*XLEN +: XLEN];
         for (int j = 0; j < NUM_PROD; j++) begin
            if (!hit_any[i] && src_en[i] && prod_en[j] && !zero_src[i] &&
                (prod_addr[j*RA_W +: RA_W] == src_addr[i*RA_W +: RA_W])) begin
               hit_any[i]  = 1'b1;
               live_val[i] = prod_data[j*XLEN +: XLEN];
               live_ok[i]  = !prod_pend[j];
            end
         end
         if (zero_src[i]) begin
            live_val[i] = '0;
         end
      end
   end

   always_comb begin
      out_data   = '0;
      out_src_ok = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         out_src_ok[i]              = !src_en[i] || cap_flag[i] || live_ok[i];
         out_data[i*XLEN +: XLEN]   = cap_flag[i] ? cap_data[i] : live_val[i];
      end
      out_valid = &out_src_ok;
   end

   assign stall_inc = (|src_en) && !out_valid && !cons_flush;

   // Capture stage: first resolved value is frozen until the instruction leaves EXE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_flag <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            cap_data[i] <= '0;
         end
      end else if (cons_ready || cons_flush) begin
         cap_flag <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            cap_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!cap_flag[i] && live_ok[i]) begin
               cap_flag[i] <= 1'b1;
               cap_data[i] <= live_val[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_inc) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_operand_bypass_net.sv
// Scoreboard bench for operand_bypass_net: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_operand_bypass_net;

   localparam int XLEN = 64;
   localparam int NS   = 3;
   localparam int NP   = 2;
   localparam int RAW  = 5;
   localparam int CW   = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cons_ready, cons_flush;
   logic [NS-1:0]     src_en;
   logic [NS*RAW-1:0] src_addr;
   logic [NS*XLEN-1:0] src_rf;
   logic [NP-1:0]     prod_en;
   logic [NP*RAW-1:0] prod_addr;
   logic [NP*XLEN-1:0] prod_data;
   logic [NP-1:0]     prod_pend;
   logic              out_valid;
   logic [NS*XLEN-1:0] out_data;
   logic [NS-1:0]     out_src_ok;
   logic [CW-1:0]     stall_cnt;

   operand_bypass_net #(
      .XLEN(XLEN), .NUM_SRC(NS), .NUM_PROD(NP), .RA_W(RAW), .ZERO_REG(1), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cons_ready(cons_ready), .cons_flush(cons_flush),
      .src_en(src_en), .src_addr(src_addr), .src_rf(src_rf),
      .prod_en(prod_en), .prod_addr(prod_addr), .prod_data(prod_data), .prod_pend(prod_pend),
      .out_valid(out_valid), .out_data(out_data), .out_src_ok(out_src_ok), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      bit           valid;
      logic [NS-1:0] ok;
      logic [63:0]  d [NS];
      logic [NS-1:0] dmask;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, id, got, exp);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("out_valid", e.id, 64'(out_valid), 64'(e.valid));
         chk("out_src_ok", e.id, 64'(out_src_ok), 64'(e.ok));
         chk("stall_cnt", e.id, 64'(stall_cnt), 64'(e.cnt));
         for (int i = 0; i < NS; i++) begin
            if (e.dmask[i]) chk($sformatf("out_data[%0d]", i), e.id, out_data[i*XLEN +: XLEN], e.d[i]);
         end
      end
   end

   task automatic push_exp(input int id, input bit v, input logic [NS-1:0] ok,
                           input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                           input logic [NS-1:0] dm, input logic [CW-1:0] c);
      exp_t e;
      e.id = id; e.valid = v; e.ok = ok; e.dmask = dm; e.cnt = c;
      e.d[0] = d0; e.d[1] = d1; e.d[2] = d2;
      q.push_back(e);
   endtask

   task automatic set_src(input int i, input logic en, input logic [RAW-1:0] a, input logic [63:0] rf);
      src_en[i] = en;
      src_addr[i*RAW +: RAW] = a;
      src_rf[i*XLEN +: XLEN] = rf;
   endtask

   task automatic set_prod(input int j, input logic en, input logic [RAW-1:0] a,
                           input logic [63:0] d, input logic p);
      prod_en[j] = en;
      prod_addr[j*RAW +: RAW] = a;
      prod_data[j*XLEN +: XLEN] = d;
      prod_pend[j] = p;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [CW-1:0] exp_cnt;
   bit            off;

   initial begin
      rst_n = 1'b0; cons_ready = 1'b0; cons_flush = 1'b0;
      src_en = '0; src_addr = '0; src_rf = '0;
      prod_en = '0; prod_addr = '0; prod_data = '0; prod_pend = '0;

      // Reset state: nothing enabled, all ok, counter clear
      cyc();
      push_exp(0, 1, 3'b111, 0, 0, 0, 3'b000, 0);

      // Youngest producer wins over older
      cyc(); rst_n = 1'b1; cons_ready = 1'b1;
      set_src(0, 1, 5, 64'h99); set_prod(0, 1, 5, 64'hAA, 0); set_prod(1, 1, 5, 64'hBB, 0);
      push_exp(1, 1, 3'b111, 64'hAA, 0, 0, 3'b001, 0);

      // Mixed: src0 via prod1, src1 from RF, src2 via prod0
      cyc();
      set_src(1, 1, 9, 64'h1234); set_src(2, 1, 6, 64'h77);
      set_prod(0, 1, 6, 64'hCC, 0); set_prod(1, 1, 5, 64'hBB, 0);
      push_exp(2, 1, 3'b111, 64'hBB, 64'h1234, 64'hCC, 3'b111, 0);

      // Disabled producer is ignored
      cyc();
      prod_en[0] = 1'b0;
      push_exp(3, 1, 3'b111, 64'hBB, 64'h1234, 64'h77, 3'b111, 0);

      // Pending youngest blocks, no fall-through to older producer
      cyc(); cons_ready = 1'b0;
      src_en = '0; set_src(1, 1, 7, 64'h5);
      set_prod(0, 1, 7, 64'hDEAD, 1); set_prod(1, 1, 7, 64'h11, 0);
      push_exp(4, 0, 3'b101, 0, 0, 0, 3'b000, 0);

      cyc(); cons_ready = 1'b1;
      set_prod(0, 1, 7, 64'h22, 0);
      push_exp(5, 1, 3'b111, 0, 64'h22, 0, 3'b010, 1);

      // Captured src0 holds while src1 blocked and prod1 changes/retires
      cyc(); cons_ready = 1'b0;
      src_en = '0; set_src(0, 1, 3, 64'h123); set_src(1, 1, 4, 64'h0);
      set_prod(0, 1, 4, 64'h0, 1); set_prod(1, 1, 3, 64'h33, 0);
      push_exp(6, 0, 3'b101, 64'h33, 0, 0, 3'b001, 1);

      cyc(); set_prod(1, 1, 3, 64'h44, 0);
      push_exp(7, 0, 3'b101, 64'h33, 0, 0, 3'b001, 2);

      cyc(); set_prod(1, 1, 9, 64'h44, 0);
      push_exp(8, 0, 3'b101, 64'h33, 0, 0, 3'b001, 3);

      cyc(); cons_ready = 1'b1; set_prod(0, 1, 4, 64'h55, 0);
      push_exp(9, 1, 3'b111, 64'h33, 64'h55, 0, 3'b011, 4);

      // After consume the capture is gone: src0 now reads RF
      cyc();
      push_exp(10, 1, 3'b111, 64'h123, 64'h55, 0, 3'b011, 4);

      // x0 never forwarded and reads zero, even with pending producer to x0
      cyc();
      src_en = '0; set_src(0, 1, 0, 64'hFF);
      set_prod(0, 1, 0, 64'h5, 0); set_prod(1, 1, 0, 64'h7, 1);
      push_exp(11, 1, 3'b111, 0, 0, 0, 3'b001, 4);

      // Flush+ready together clear captures
      cyc(); cons_ready = 1'b0;
      src_en = '0; set_src(0, 1, 3, 64'h0); set_src(1, 1, 4, 64'h0);
      set_prod(0, 1, 4, 64'h0, 1); set_prod(1, 1, 3, 64'h66, 0);
      push_exp(12, 0, 3'b101, 64'h66, 0, 0, 3'b001, 4);

      cyc(); cons_ready = 1'b1; cons_flush = 1'b1; set_prod(1, 1, 3, 64'h77, 0);
      push_exp(13, 0, 3'b101, 64'h66, 0, 0, 3'b001, 5);

      cyc(); cons_ready = 1'b0; cons_flush = 1'b0;
      push_exp(14, 0, 3'b101, 64'h77, 0, 0, 3'b001, 5);

      cyc(); set_prod(1, 1, 3, 64'h88, 0);
      push_exp(15, 0, 3'b101, 64'h77, 0, 0, 3'b001, 6);

      // Asynchronous reset mid-stall
      cyc(); rst_n = 1'b0;
      push_exp(16, 0, 3'b101, 64'h88, 0, 0, 3'b001, 0);

      cyc(); rst_n = 1'b1;
      push_exp(17, 0, 3'b101, 64'h88, 0, 0, 3'b001, 0);

      // Saturation at 15; idle (src_en=0) cycles do not count
      exp_cnt = 1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         off = (k >= 5 && k <= 7);
         cons_ready = off;
         src_en = off ? 3'b000 : 3'b011;
         if (off) push_exp(18 + k, 1, 3'b111, 0, 0, 0, 3'b000, exp_cnt);
         else begin
            push_exp(18 + k, 0, 3'b101, 64'h88, 0, 0, 3'b001, exp_cnt);
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'h1;
         end
      end

      cyc();
      src_en = '0; cons_ready = 1'b1;
      for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain got=%0d pending expected=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
